// File: rtl/ship_render_sequencer.sv
// Per-frame ship sequencer: latches the new pose, erases the previous sprite footprint,
// then releases the sprite drawer and forwards its pixel stream to the VGA write port.
module ship_render_sequencer #(
    parameter int          SPRITE_W     = 32,
    parameter int          SPRITE_H     = 32,
    parameter logic [2:0]  BG_COLOR     = 3'b000,
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter int          DRAW_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [5:0] dir_in,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic       draw_we,
    input  logic [2:0] draw_color,
    output logic       drawer_hold,
    output logic [9:0] draw_pos_x,
    output logic [9:0] draw_pos_y,
    output logic [5:0] draw_dir,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic       vga_we,
    output logic [2:0] vga_color,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int XW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int YW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int NPIX = SPRITE_W * SPRITE_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int TW   = $clog2(DRAW_TIMEOUT + 1);

    localparam logic [10:0] SCR_W = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H = 11'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [CW-1:0] wcnt;
    logic [TW-1:0] tcnt;
    logic [9:0]    old_x, old_y;
    logic          have_old;

    logic [10:0] erase_sx, erase_sy;
    logic        erase_vis, draw_vis;
    logic        erase_last, draw_full, draw_tmo;

    // Sums kept at 11 bits so footprints hanging off the screen edge clip instead of wrapping.
    assign erase_sx   = {1'b0, old_x} + 11'(ex);
    assign erase_sy   = {1'b0, old_y} + 11'(ey);
    assign erase_vis  = (erase_sx < SCR_W) && (erase_sy < SCR_H);
    assign draw_vis   = ({1'b0, draw_x} < SCR_W) && ({1'b0, draw_y} < SCR_H);
    assign erase_last = (ex == XW'(SPRITE_W - 1)) && (ey == YW'(SPRITE_H - 1));
    assign draw_full  = draw_we && (wcnt == CW'(NPIX - 1));
    assign draw_tmo   = (tcnt == TW'(DRAW_TIMEOUT - 1));

    always_comb begin
        state_next  = state;
        drawer_hold = 1'b1;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_tick)
                    state_next = have_old ? S_ERASE : S_DRAW;
            end
            S_ERASE: begin
                if (erase_last)
                    state_next = S_DRAW;
            end
            S_DRAW: begin
                drawer_hold = 1'b0;
                if (draw_full || draw_tmo)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            have_old    <= 1'b0;
            old_x       <= '0;
            old_y       <= '0;
            ex          <= '0;
            ey          <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            draw_pos_x  <= '0;
            draw_pos_y  <= '0;
            draw_dir    <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_we      <= 1'b0;
            vga_color   <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state  <= state_next;
            vga_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        draw_pos_x <= pos_x;
                        draw_pos_y <= pos_y;
                        draw_dir   <= dir_in;
                        ex         <= '0;
                        ey         <= '0;
                        wcnt       <= '0;
                        tcnt       <= '0;
                    end
                end
                S_ERASE: begin
                    vga_x     <= erase_sx[9:0];
                    vga_y     <= erase_sy[9:0];
                    vga_color <= BG_COLOR;
                    vga_we    <= erase_vis;
                    if (ex == XW'(SPRITE_W - 1)) begin
                        ex <= '0;
                        ey <= ey + 1'b1;
                    end else begin
                        ex <= ex + 1'b1;
                    end
                end
                S_DRAW: begin
                    vga_x     <= draw_x;
                    vga_y     <= draw_y;
                    vga_color <= draw_color;
                    vga_we    <= draw_we && draw_vis;
                    tcnt      <= tcnt + 1'b1;
                    // Clipped drawer writes still count toward sprite completion.
                    if (draw_we)
                        wcnt <= wcnt + 1'b1;
                    if (draw_tmo && !draw_full)
                        timeout_err <= 1'b1;
                end
                S_DONE: begin
                    old_x    <= draw_pos_x;
                    old_y    <= draw_pos_y;
                    have_old <= 1'b1;
                end
                default: ;
            endcase
            if (frame_tick && (state != S_IDLE))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ship_render_sequencer.sv
// Directed bench for ship_render_sequencer: a behavioural drawer feeds pixels while a
// negedge logger records every VGA write for hand-computed position/count checks.
module tb_ship_render_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic [9:0] pos_x, pos_y;
    logic [5:0] dir_in;
    logic [9:0] draw_x, draw_y;
    logic       draw_we;
    logic [2:0] draw_color;
    logic       drawer_hold;
    logic [9:0] draw_pos_x, draw_pos_y;
    logic [5:0] draw_dir;
    logic [9:0] vga_x, vga_y;
    logic       vga_we;
    logic [2:0] vga_color;
    logic       busy, done, overrun, timeout_err;

    ship_render_sequencer dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .pos_x(pos_x), .pos_y(pos_y), .dir_in(dir_in),
        .draw_x(draw_x), .draw_y(draw_y), .draw_we(draw_we), .draw_color(draw_color),
        .drawer_hold(drawer_hold), .draw_pos_x(draw_pos_x), .draw_pos_y(draw_pos_y),
        .draw_dir(draw_dir), .vga_x(vga_x), .vga_y(vga_y), .vga_we(vga_we),
        .vga_color(vga_color), .busy(busy), .done(done), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  t_tick, t_rel, t_done, t_first, ndone;
    bit  aborted;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vga_we === 1'b1)
            wq.push_back('{x: int'(vga_x), y: int'(vga_y), c: int'(vga_color), t: cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_c(input int c);
        int k = 0;
        foreach (wq[i]) if (wq[i].c == c) k++;
        return k;
    endfunction

    // Runs one frame: pulses frame_tick, then plays a drawer that emits a 32x32 raster in
    // colour 5 whenever released. Optional extra tick and mid-draw reset injection.
    task automatic run_frame(input int px, input int py, input bit stall,
                             input int tick2_at, input int rst_at);
        int n = 0;
        int i;
        wq.delete();
        ndone   = 0;
        t_rel   = -1;
        t_done  = -1;
        t_first = -1;
        aborted = 1'b0;
        @(posedge clk); #1;
        frame_tick = 1'b1;
        pos_x = 10'(px);
        pos_y = 10'(py);
        dir_in = 6'(px % 64);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        pos_x = 10'd777;
        pos_y = 10'd333;
        dir_in = 6'd63;
        t_tick = cyc;
        for (i = 0; i < 8000; i++) begin
            if (done) begin
                ndone++;
                if (t_done < 0) t_done = cyc;
            end
            if (!drawer_hold && t_rel < 0) t_rel = cyc;
            if (!busy) break;
            if (i == tick2_at) begin
                frame_tick = 1'b1;
                pos_x = 10'd300;
                pos_y = 10'd300;
            end else begin
                frame_tick = 1'b0;
            end
            if (rst_at >= 0 && n == rst_at) begin
                reset_n = 1'b0;
                draw_we = 1'b0;
                @(posedge clk); #1;
                aborted = 1'b1;
                return;
            end
            if (!drawer_hold && !stall && n < 1024) begin
                draw_we = 1'b1;
                draw_x = 10'(px + n % 32);
                draw_y = 10'(py + n / 32);
                if (n == 0) t_first = cyc;
                n++;
            end else begin
                draw_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        draw_we = 1'b0;
        frame_tick = 1'b0;
        if (i >= 8000) check("frame_terminates", 32'd0, 32'd1);
    endtask

    initial begin
        int wsz;
        reset_n = 1'b0; frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; dir_in = '0;
        draw_x = '0; draw_y = '0; draw_we = 1'b0; draw_color = 3'd5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", drawer_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_vga_we", vga_we, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_pos_x", draw_pos_x, 0);
        reset_n = 1'b1;

        // Frame 1: no previous footprint, straight to draw.
        run_frame(100, 50, 1'b0, -1, -1);
        check("f1_release_delay", t_rel - t_tick, 0);
        check("f1_erase_writes", count_c(0), 0);
        check("f1_draw_writes", count_c(5), 1024);
        check("f1_first_x", wq[0].x, 100);
        check("f1_first_y", wq[0].y, 50);
        check("f1_latency", wq[0].t - t_first, 1);
        check("f1_done_pulses", ndone, 1);
        check("f1_old_x", dut.old_x, 100);
        check("f1_old_y", dut.old_y, 50);
        check("f1_pos_held", draw_pos_x, 100);
        check("f1_dir", draw_dir, 100 % 64);

        // Frame 2: erase (100,50) footprint row-major.
        run_frame(120, 60, 1'b0, -1, -1);
        check("f2_erase_writes", count_c(0), 1024);
        check("f2_erase_t0", wq[0].t - t_tick, 1);
        check("f2_w1_x", wq[0].x, 100);
        check("f2_w1_y", wq[0].y, 50);
        check("f2_w32_x", wq[31].x, 131);
        check("f2_w32_y", wq[31].y, 50);
        check("f2_w33_x", wq[32].x, 100);
        check("f2_w33_y", wq[32].y, 51);
        check("f2_last_x", wq[1023].x, 131);
        check("f2_last_y", wq[1023].y, 81);
        check("f2_last_c", wq[1023].c, 0);
        check("f2_erase_cycles", t_rel - t_tick, 1024);
        check("f2_draw_writes", count_c(5), 1024);
        check("f2_done_pulses", ndone, 1);

        // Frame 3: drawn at the bottom-right corner, so drawer output clips to 20x10.
        run_frame(620, 470, 1'b0, -1, -1);
        check("f3_erase_writes", count_c(0), 1024);
        check("f3_draw_clipped", count_c(5), 200);
        check("f3_overrun", overrun, 0);

        // Frame 4: erase of the corner footprint clips; a stray tick lands mid-erase.
        run_frame(10, 10, 1'b0, 100, -1);
        check("f4_erase_clipped", count_c(0), 200);
        check("f4_erase_x0", wq[0].x, 620);
        check("f4_erase_y0", wq[0].y, 470);
        check("f4_erase_cycles", t_rel - t_tick, 1024);
        check("f4_overrun", overrun, 1);
        check("f4_pos_unchanged", draw_pos_x, 10);
        check("f4_draw_writes", count_c(5), 1024);
        check("f4_done_pulses", ndone, 1);

        // Frame 5: stalled drawer forces the timeout exit.
        run_frame(200, 200, 1'b1, -1, -1);
        check("f5_erase_writes", count_c(0), 1024);
        check("f5_draw_writes", count_c(5), 0);
        check("f5_draw_cycles", t_done - t_rel, 4096);
        check("f5_timeout", timeout_err, 1);
        check("f5_done_pulses", ndone, 1);
        check("f5_old_x", dut.old_x, 200);
        check("f5_old_y", dut.old_y, 200);
        check("f5_overrun_sticky", overrun, 1);

        // Frame 6: reset pulled mid-draw.
        run_frame(300, 100, 1'b0, -1, 100);
        check("f6_aborted", aborted, 1);
        check("f6_vga_we", vga_we, 0);
        check("f6_hold", drawer_hold, 1);
        check("f6_busy", busy, 0);
        check("f6_have_old", dut.have_old, 0);
        check("f6_overrun_clr", overrun, 0);
        check("f6_timeout_clr", timeout_err, 0);
        reset_n = 1'b1;
        wsz = wq.size();
        repeat (3) @(posedge clk);
        #1;
        check("f6_no_writes", wq.size(), wsz);

        // Frame 7: no erase after reset.
        run_frame(5, 5, 1'b0, -1, -1);
        check("f7_release_delay", t_rel - t_tick, 0);
        check("f7_erase_writes", count_c(0), 0);
        check("f7_draw_writes", count_c(5), 1024);
        check("f7_done_pulses", ndone, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ship_render_sequencer.md
Name: ship_render_sequencer

Overview:
Per-frame sequencer that sits directly upstream of the ship sprite drawer and in front of the VGA pixel-write port.
- On each frame tick it latches the ship's new position and direction.
- It then erases the previous 32x32 footprint by writing background-colour pixels itself.
- It releases the drawer from hold and forwards the drawer's pixel stream to the VGA port, counting writes.
- When the drawer completes, it commits the new position as "old" and pulses done.

Parameters:
SPRITE_W, 32, sprite width in pixels (counter range 0..SPRITE_W-1)
SPRITE_H, 32, sprite height in pixels
BG_COLOR, 3'b000, colour written during erase
SCREEN_W, 640, writes with x >= SCREEN_W are clipped
SCREEN_H, 480, writes with y >= SCREEN_H are clipped
DRAW_TIMEOUT, 4096, max cycles spent in DRAW before forced exit

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse, start of frame update
pos_x  in  10  new ship top-left x
pos_y  in  10  new ship top-left y
dir_in  in  6  new ship direction code
draw_x  in  10  drawer pixel x
draw_y  in  10  drawer pixel y
draw_we  in  1  drawer pixel write strobe
draw_color  in  3  drawer pixel colour
drawer_hold  out  1  1 = hold drawer in reset (active-high reset of drawer)
draw_pos_x  out  10  latched position to drawer
draw_pos_y  out  10  latched position to drawer
draw_dir  out  6  latched direction to drawer
vga_x  out  10  pixel x to VGA adapter
vga_y  out  10  pixel y to VGA adapter
vga_we  out  1  pixel write enable
vga_color  out  3  pixel colour
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on frame completion
overrun  out  1  sticky: frame_tick arrived while busy
timeout_err  out  1  sticky: DRAW exited by timeout

Behaviour:

Reset (reset_n=0 at posedge):
- state=IDLE, have_old=0.
- drawer_hold=1; busy, done, overrun, timeout_err = 0.
- vga_we=0; vga_x, vga_y, vga_color = 0.
- draw_pos_x, draw_pos_y, draw_dir = 0; old_x, old_y = 0.
- Reset mid-frame aborts immediately and emits no further writes.

States:
- IDLE: on frame_tick, latch pos_x/pos_y/dir_in into draw_pos_*, clear ex=ey=0. Go to ERASE if have_old=1, otherwise go to DRAW.
- ERASE: each cycle present pixel (old_x+ex, old_y+ey, BG_COLOR) to the output register. ex increments; on ex=SPRITE_W-1, ex wraps to 0 and ey increments. After (SPRITE_W-1, SPRITE_H-1) is presented, go to DRAW. This is exactly SPRITE_W*SPRITE_H cycles, row-major, x fastest.
- DRAW: drawer_hold=0 only in this state. draw_* inputs are forwarded to the output register each cycle. Count cycles with draw_we=1 (clipped pixels still count). Go to DONE when the count reaches SPRITE_W*SPRITE_H; the final write is forwarded. If DRAW_TIMEOUT cycles elapse first, go to DONE and set timeout_err.
- DONE: one cycle. old_x<=draw_pos_x, old_y<=draw_pos_y, have_old<=1, done=1. Go to IDLE.

Output timing:
- vga_* are registered: one cycle latency from the counter value in ERASE, or from the draw_* inputs in DRAW.
- vga_we=0 in IDLE and DONE, and for any clipped pixel.
- Clip rule: compute old_x+ex and old_y+ey at 11 bits. If the sum >= SCREEN_W (x) or >= SCREEN_H (y), write vga_we=0. vga_x/vga_y carry the low 10 bits.

Handshake and interaction rules:
- drawer_hold rises in the same cycle as DONE. The drawer therefore restarts from its reset state every frame.
- frame_tick while busy=1 is ignored and sets overrun. A frame_tick coincident with DONE is also ignored and sets overrun.
- dir_in/pos_x/pos_y changes outside the IDLE latch cycle have no effect.

Test Plan:
- Reset, then frame_tick with pos=(100,50). Required: no erase writes (have_old=0); drawer_hold falls on the next cycle; 1024 draw_we pulses forwarded with 1-cycle latency; done pulses once; old=(100,50).
- Second frame_tick with pos=(120,60). Required: 1024 consecutive vga_we writes, colour 000. First write at (100,50), 32nd at (131,50), 33rd at (100,51), last at (131,81). Then 1024 draw writes, then done.
- Old position (620,470). Required: erase clips x>=640 and y>=480. Exactly 20*10=200 vga_we pulses, and 1024 erase cycles still elapse.
- frame_tick asserted in the middle of ERASE. Required: overrun=1 and stays 1, the frame proceeds unchanged, and done pulses once.
- Drawer stalled (draw_we never asserted). Required: DRAW exits after 4096 cycles, timeout_err=1, done pulses, old_x/old_y updated.
- reset_n=0 asserted mid-DRAW. Required: next cycle vga_we=0, drawer_hold=1, busy=0, have_old=0; the next frame performs no erase.
